// File: rtl/cpu_pkg.sv
// Shared register-file write-side types and constants.
package cpu_pkg;

  localparam logic [3:0] REG_PC   = 4'd15;
  localparam int         NUM_REGS = 15;

  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of multicycle writeback requests.
// With WB_SCOREBOARD_EN defined, it also exports the storage array and a
// per-slot valid vector so the parent can build the pending-write scoreboard.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       din,
  output wb_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [DEPTH-1:0] entry_valid,
  output wb_req_t          entries [DEPTH]
`endif
);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state with synchronous reset; a reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] off;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, off} < count_q);
      entries[i]     = mem_q[i];
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority,
// multicycle results queue in wb_fifo and drain into idle slots. Writes to the
// PC (r15) are dropped. A starvation counter raises a one-cycle wb_hold
// request when queued results have waited STARVE_LIMIT cycles.
// Optional feature macro: WB_SCOREBOARD_EN exports the pending-write vector.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_we,
  input  logic [3:0]  a_wa,
  input  logic [31:0] a_wd,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_wa,
  input  logic [31:0] b_wd,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        wb_hold
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [NUM_REGS-1:0] pending
`endif
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  logic          fifo_full, fifo_empty, fifo_push, pop;
  logic [CW-1:0] fifo_count;
  wb_req_t       fifo_head;
  logic          a_ok, starved;

  logic          we3_q, we3_d;
  logic [3:0]    wa3_q, wa3_d;
  logic [31:0]   wd3_q, wd3_d;
  logic          hold_q, hold_d;
  logic [SW-1:0] starve_q, starve_d, starve_inc;

  assign a_ok      = a_we && (a_wa != REG_PC);
  assign b_ready   = !reset && !fifo_full;
  assign fifo_push = b_valid && b_ready && (b_wa != REG_PC);
  assign pop       = !a_ok && !fifo_empty;
  assign starved   = (fifo_count != '0) && !pop;

  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;
  assign wb_hold = hold_q;

`ifdef WB_SCOREBOARD_EN
  logic [DEPTH-1:0] entry_valid;
  wb_req_t          entries [DEPTH];
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .pop         (pop),
    .din         ('{wa: b_wa, wd: b_wd}),
    .dout        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
`ifdef WB_SCOREBOARD_EN
    ,
    .entry_valid (entry_valid),
    .entries     (entries)
`endif
  );

  // Issue select: pipeline write, else FIFO head, else idle with address/data held.
  always_comb begin
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (a_ok) begin
      we3_d = 1'b1;
      wa3_d = a_wa;
      wd3_d = a_wd;
    end else if (!fifo_empty) begin
      we3_d = 1'b1;
      wa3_d = fifo_head.wa;
      wd3_d = fifo_head.wd;
    end
  end

  // Starvation tracking: reaching the limit fires one hold pulse and restarts the count.
  always_comb begin
    starve_inc = starve_q + 1'b1;
    starve_d   = '0;
    hold_d     = 1'b0;
    if (starved) begin
      if (starve_inc == STARVE_MAX) begin
        hold_d = 1'b1;
      end else begin
        starve_d = starve_inc;
      end
    end
  end

  // Registered write port, hold request and starvation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      hold_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // Pending bit per register for every live queued entry.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entries[i].wa != REG_PC)) begin
        pending[entries[i].wa] = 1'b1;
      end
    end
  end
`endif

endmodule
